// File: rtl/op_seq_pkg.sv
// Shared types and constants for the operation sequencer.
package op_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Opcode encoding; the opcode also indexes the unit DONE/result lanes
  localparam logic [1:0] OP_LSHIFT = 2'b00;
  localparam logic [1:0] OP_RSHIFT = 2'b01;
  localparam logic [1:0] OP_ZERO   = 2'b10;
  localparam logic [1:0] OP_DIV    = 2'b11;

  // Width of the WAIT-phase cycle counter (TIMEOUT up to 255)
  localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/op_seq_watchdog.sv
// WAIT-phase cycle counter. Cleared on entry to the operation, counts
// while enabled, and flags the last allowed WAIT cycle.
module op_seq_watchdog
  import op_seq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  // Count WAIT cycles; the count restarts for every new operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  // High during the TIMEOUT-th WAIT cycle, the last one allowed to see done
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/op_sequencer.sv
// Operation sequencer: captures operands, strobes the selected unit,
// waits for its DONE and returns the unit's 3-bit result zero-extended.
// Optional WAIT timeout with sticky err flag: define OP_SEQ_TIMEOUT_EN.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [2:0]  portA,
  input  logic [2:0]  portB,
  input  logic [1:0]  opcode,
  input  logic [3:0]  unit_done,
  input  logic [11:0] unit_res,
  output logic [2:0]  op_a,
  output logic [2:0]  op_b,
  output logic [3:0]  init,
  output logic [15:0] result,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("op_sequencer: TIMEOUT must lie in 1..255");
  end

  state_t     state, state_nxt;
  logic [1:0] opc;
  logic [2:0] slice;
  logic       done_sel;
  logic       accept;
  logic       timeout_hit;

  assign accept   = (state == S_IDLE) && go;
  assign done_sel = unit_done[opc];

`ifdef OP_SEQ_TIMEOUT_EN
  logic err_q;

  op_seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == S_START),
    .enable (state == S_WAIT),
    .expired(timeout_hit)
  );

  // Sticky timeout flag, cleared when the next operation is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state == S_WAIT && !done_sel && timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Select the result lane of the captured opcode
  always_comb begin
    slice = unit_res[2:0];
    case (opc)
      OP_LSHIFT: slice = unit_res[2:0];
      OP_RSHIFT: slice = unit_res[5:3];
      OP_ZERO:   slice = unit_res[8:6];
      OP_DIV:    slice = unit_res[11:9];
      default:   slice = unit_res[2:0];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; done wins over timeout in the last WAIT cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done_sel) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    init  = 4'b0000;
    valid = 1'b0;
    busy  = 1'b1;
    case (state)
      S_IDLE:  busy  = 1'b0;
      S_START: init  = 4'b0001 << opc;
      S_DONE:  valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept; result load on the selected unit's done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= 3'd0;
      op_b   <= 3'd0;
      opc    <= OP_LSHIFT;
      result <= 16'd0;
    end else begin
      if (accept) begin
        op_a <= portA;
        op_b <= portB;
        opc  <= opcode;
      end
      if (state == S_WAIT && done_sel) begin
        result <= {13'd0, slice};
      end
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: randomized operations, directed
// corner cases, and a monitor that checks every valid strobe.
module tb_op_sequencer;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [2:0]  portA, portB;
  logic [1:0]  opcode;
  logic [3:0]  unit_done;
  logic [11:0] unit_res;
  logic [2:0]  op_a, op_b;
  logic [3:0]  init;
  logic [15:0] result;
  logic        valid, busy, err;

  op_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .go(go), .portA(portA), .portB(portB),
    .opcode(opcode), .unit_done(unit_done), .unit_res(unit_res),
    .op_a(op_a), .op_b(op_b), .init(init), .result(result),
    .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  a;
    logic [2:0]  b;
    int          vc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          init_cnt = 0;
  int          busy_chk = -1;
  logic [15:0] last_result = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the result a unit delivers is its 3-bit lane, zero-extended
  function automatic logic [15:0] lane(input logic [11:0] res, input logic [1:0] op);
    return 16'((res >> (3 * op)) & 12'h7);
  endfunction

  // Monitor: every valid must match the oldest expected completion
  always @(negedge clk) begin
    if (rst) begin
      busy_chk = -1;
    end else begin
      if (init != 4'd0) init_cnt++;
      if (cyc == busy_chk) begin
        chk("busy_after_valid", {31'd0, busy}, 32'd0);
        chk("valid_one_cycle", {31'd0, valid}, 32'd0);
        busy_chk = -1;
      end
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", {16'd0, result}, {16'd0, e.res});
          chk("op_a", {29'd0, op_a}, {29'd0, e.a});
          chk("op_b", {29'd0, op_b}, {29'd0, e.b});
          chk("valid_cycle", cyc, e.vc);
          busy_chk = cyc + 1;
        end
      end
    end
  end

  // Wait (bounded) until the sequencer is idle; called at a negedge
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_wait_timeout", 32'd1, 32'd0);
  endtask

  // Issue go, then check the START cycle; returns the START cycle number
  task automatic start_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                          input logic [3:0] start_mask, output int n1);
    wait_idle();
    portA = a; portB = b; opcode = op; go = 1'b1; unit_done = 4'd0;
    @(negedge clk);
    go = 1'b0;
    portA = 3'($urandom); portB = 3'($urandom); opcode = 2'($urandom);
    unit_done = start_mask;
    unit_res = 12'($urandom);
    n1 = cyc;
    chk("init_start", {28'd0, init}, {28'd0, 4'b0001 << op});
    chk("busy_start", {31'd0, busy}, 32'd1);
    chk("err_cleared", {31'd0, err}, 32'd0);
  endtask

  // One complete operation: done on the selected unit in WAIT cycle 'delay'
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                        input logic [11:0] res, input int delay, input logic [3:0] start_mask,
                        input bit noise);
    int n1;
    exp_t e;
    logic [3:0] sel;
    sel = 4'b0001 << op;
    start_op(a, b, op, start_mask, n1);
    e.res = lane(res, op); e.a = a; e.b = b; e.vc = n1 + 2 + delay;
    q.push_back(e);
    last_result = e.res;
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      if (i == 0) chk("init_wait", {28'd0, init}, 32'd0);
      unit_done = (noise ? 4'($urandom) & ~sel : 4'd0) | ((i == delay) ? sel : 4'd0);
      unit_res  = (i == delay) ? res : 12'($urandom);
    end
    @(negedge clk);
    unit_done = 4'd0;
    unit_res  = 12'($urandom);
  endtask

  initial begin
    int n1, n0, ic0, next_free;
    logic [2:0]  ba[14], bb[14];
    logic [1:0]  bo[14];
    logic [11:0] br[14];

    rst = 1'b1; go = 1'b0; portA = 3'd0; portB = 3'd0; opcode = 2'd0;
    unit_done = 4'd0; unit_res = 12'd0;
    repeat (2) @(negedge clk);
    chk("rst_init", {28'd0, init}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_ops", {26'd0, op_a, op_b}, 32'd0);
    rst = 1'b0;

    // Basic LSHIFT with done two cycles after init
    run_op(3'd5, 3'd1, 2'b00, 12'b000_000_000_010, 1, 4'd0, 1'b0);
    // DIV with done in the first WAIT cycle
    run_op(3'd3, 3'd6, 2'b11, {3'd2, 9'h1FF}, 0, 4'd0, 1'b0);
    // ZERO with stray dones during START and on other units
    run_op(3'd7, 3'd2, 2'b10, {3'd1, 3'd5, 3'd3, 3'd6}, 2, 4'b0110, 1'b1);

    // Randomized operations
    for (int t = 0; t < 25; t++) begin
      run_op(3'($urandom), 3'($urandom), 2'($urandom), 12'($urandom),
             int'($urandom_range(0, 3)), 4'($urandom), 1'b1);
    end

    // go held high for 10 cycles with changing inputs; all units always done
    wait_idle();
    for (int c = 0; c < 14; c++) begin
      ba[c] = 3'($urandom); bb[c] = 3'($urandom);
      bo[c] = 2'($urandom); br[c] = 12'($urandom);
    end
    n0 = cyc; ic0 = init_cnt; next_free = 0;
    for (int c = 0; c < 14; c++) begin
      go = (c < 10); portA = ba[c]; portB = bb[c]; opcode = bo[c];
      unit_res = br[c]; unit_done = 4'hF;
      // Each accepted op takes 4 cycles when done is immediate
      if (c < 10 && c >= next_free) begin
        exp_t e;
        e.res = lane(br[c + 2], bo[c]); e.a = ba[c]; e.b = bb[c]; e.vc = n0 + c + 3;
        q.push_back(e);
        last_result = e.res;
        next_free = c + 4;
      end
      @(negedge clk);
    end
    go = 1'b0; unit_done = 4'd0;
    #1;
    chk("burst_init_count", init_cnt - ic0, 3);

    // Reset in the middle of WAIT
    @(negedge clk);
    start_op(3'd4, 3'd4, 2'b01, 4'd0, n1);
    @(negedge clk);
    unit_done = 4'd0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_init", {28'd0, init}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_ops", {26'd0, op_a, op_b}, 32'd0);
    last_result = 16'd0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_op(3'd1, 3'd2, 2'b01, {3'd0, 3'd0, 3'd6, 3'd0}, 1, 4'd0, 1'b0);

`ifdef OP_SEQ_TIMEOUT_EN
    // Timeout: no done for TMO WAIT cycles
    start_op(3'd2, 3'd3, 2'b00, 4'b0001, n1);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      unit_done = 4'($urandom) & 4'b1110;
    end
    chk("tmo_err_before", {31'd0, err}, 32'd0);
    chk("tmo_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    unit_done = 4'd0;
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_result_kept", {16'd0, result}, {16'd0, last_result});
    run_op(3'd6, 3'd5, 2'b11, 12'hA5A, 0, 4'd0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
